// File: rtl/ripemd_pkg.sv
// ripemd_pkg: shared RIPEMD-160 constants and helpers.
//   - RMD_IV0..RMD_IV4 : RIPEMD-160 initial chaining values
//   - PAD_80 / PAD_LEN : fixed padding words for a 32-byte message
//   - bb_state_e       : block-builder state encoding
//   - bswap32          : 32-bit byte reversal (big-endian word -> LE load)
package ripemd_pkg;

  localparam logic [31:0] RMD_IV0 = 32'h6745_2301;
  localparam logic [31:0] RMD_IV1 = 32'hEFCD_AB89;
  localparam logic [31:0] RMD_IV2 = 32'h98BA_DCFE;
  localparam logic [31:0] RMD_IV3 = 32'h1032_5476;
  localparam logic [31:0] RMD_IV4 = 32'hC3D2_E1F0;

  // 0x80 terminator byte right after the 32-byte digest, and the bit
  // length (256) in the little-endian length field.
  localparam logic [31:0] PAD_80  = 32'h0000_0080;
  localparam logic [31:0] PAD_LEN = 32'h0000_0100;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_ISSUE   = 1'b1
  } bb_state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ripemd_block_builder.sv
// ripemd_block_builder: turns a streamed SHA-256 digest (8 words, H0 first)
// into one padded RIPEMD-160 message block, with credit-based flow control
// toward the downstream RIPEMD-160 pipeline.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_valid/s_ready     digest word handshake; s_data word, s_last final word
//   o_valid             one-cycle pulse, block holds a new padded block
//   block[511:0]        X[j] at bits [511-32j -: 32]
//   done_i              downstream completion pulse, returns one credit
//   err                 one-cycle protocol-error pulse
module ripemd_block_builder
  import ripemd_pkg::*;
#(
  parameter int CREDITS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         o_valid,
  output logic [511:0] block,
  input  logic         done_i,
  output logic         err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  bb_state_e      state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [CW-1:0]  cred_q, cred_d;
  logic           err_q, err_d;
  logic [7:0][31:0] x_q;    // collection buffer, index = word number
  logic [7:0][31:0] blk_q;  // copy of the last issued block
  logic           accept, issue;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cred_d  = cred_q;
    err_d   = 1'b0;
    s_ready = (state_q == ST_COLLECT);
    issue   = (state_q == ST_ISSUE) && (cred_q != '0);
    accept  = s_valid && s_ready;

    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          if (cnt_q == 3'd7) begin
            state_d = ST_ISSUE;
            cnt_d   = 3'd0;
            err_d   = !s_last;        // 8th word without s_last: still issue
          end else if (s_last) begin
            cnt_d = 3'd0;             // early termination: drop partial digest
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_ISSUE: if (issue) state_d = ST_COLLECT;
      default:  state_d = ST_COLLECT;
    endcase

    // A credit returned in the issue cycle cancels the one consumed.
    if (issue && !done_i) begin
      cred_d = cred_q - 1'b1;
    end else if (done_i && !issue) begin
      if (cred_q == CRED_MAX) err_d = 1'b1;   // spurious return, ignored
      else                    cred_d = cred_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      cnt_q   <= 3'd0;
      cred_q  <= CRED_MAX;
      err_q   <= 1'b0;
      x_q     <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      if (accept) x_q[cnt_q] <= bswap32(s_data);
      if (issue)  blk_q      <= x_q;
    end
  end

  // In the issue cycle the buffer is shown directly; afterwards the copy
  // keeps the block stable while the buffer refills for the next digest.
  always_comb begin
    block = '0;
    for (int j = 0; j < 8; j++)
      block[511-32*j -: 32] = issue ? x_q[j] : blk_q[j];
    block[511-32*8  -: 32] = PAD_80;
    block[511-32*14 -: 32] = PAD_LEN;
  end

  assign o_valid = issue;
  assign err     = err_q;

endmodule

// File: doc/ripemd_block_builder.md
RIPEMD_BLOCK_BUILDER -- requirements
Module: ripemd_block_builder

Interface
REQ-001 SHALL have parameter CREDITS, default 1, meaning the maximum number of blocks in flight in the downstream RIPEMD-160 pipeline (1..15).
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_valid  input  1  a SHA-256 digest word is present on s_data.
REQ-005 SHALL have port s_ready  output  1  the block accepts a word this cycle.
REQ-006 SHALL have port s_data  input  32  SHA-256 digest word H0..H7, big-endian, H0 first.
REQ-007 SHALL have port s_last  input  1  marks the final digest word.
REQ-008 SHALL have port o_valid  output  1  one-cycle pulse; block is a new padded RIPEMD-160 message block.
REQ-009 SHALL have port block  output  512  padded block; X[j] at bits [511-32j : 480-32j].
REQ-010 SHALL have port done_i  input  1  downstream digest-complete pulse; returns one credit.
REQ-011 SHALL have port err  output  1  one-cycle protocol-error pulse.

Function
REQ-012 SHALL transfer a word when s_valid and s_ready are both 1.
REQ-013 SHALL store the k-th accepted word (k = 0..7) byte-swapped into X[k] (0xAABBCCDD -> 0xDDCCBBAA).
REQ-014 SHALL drive constant padding: X[8]=0x00000080, X[9..13]=0, X[14]=0x00000100, X[15]=0.
REQ-015 SHALL implement states COLLECT (s_ready=1, word counter 0..7) and ISSUE (s_ready=0).
REQ-016 SHALL move COLLECT->ISSUE on acceptance of word 7.
REQ-017 SHALL leave ISSUE when credits>0: o_valid=1 for exactly that cycle, credits decremented, return to COLLECT with the counter at 0.
REQ-018 SHALL give a latency of one cycle: word 7 accepted in cycle N -> o_valid in cycle N+1 when a credit is available.
REQ-019 SHALL hold block stable from the o_valid cycle until the next o_valid; X[0..7] SHALL NOT be overwritten while in ISSUE.
REQ-020 SHALL increment credits on done_i; done_i together with issue SHALL leave credits unchanged.
REQ-021 SHALL ignore done_i when credits==CREDITS and no issue occurs in the same cycle; err SHALL pulse for 1 cycle.
REQ-022 SHALL treat s_last accepted at counter<7 as early termination: partial words discarded, counter->0, stay in COLLECT, no o_valid, err pulse for 1 cycle.
REQ-023 SHALL still issue the block when word 7 is accepted without s_last, and SHALL pulse err for 1 cycle.
REQ-024 SHALL keep s_ready=0 in ISSUE regardless of s_valid; no word is lost.

Reset
REQ-025 SHALL on rst_n=0 set state=COLLECT, counter=0, credits=CREDITS, X[0..7]=0, o_valid=0, err=0, s_ready=1 after release.
REQ-026 SHALL on reset mid-block discard the partial block and the outstanding credits; no o_valid follows release until 8 new words arrive.

Structure
REQ-027 SHALL take RIPEMD-160 IV constants, the padding words (0x80, 0x100), the state encoding and a 32-bit byte-swap function from shared package ripemd_pkg.
REQ-028 SHALL keep the credit counter inline; no sub-module required; width is clog2(CREDITS+1).

Verification
REQ-029 SHALL test SHA256("") words e3b0c442..7852b855 with s_last on word 8 -> o_valid 1 cycle later, X[0]=0x42c4b0e3, X[7]=0x55b85278, X[8]=0x80, X[14]=0x100; downstream Hash160 = b472a266d0bd89c13706a4132ccfb16f7c3b9fcb.
REQ-030 SHALL test back-to-back digests with CREDITS=1 and no done_i -> second block holds in ISSUE with s_ready=0; done_i pulse -> o_valid next cycle.
REQ-031 SHALL test s_last on word 3 -> err pulse, no o_valid, then a full 8-word digest issues normally.
REQ-032 SHALL test done_i with credits full -> err pulse, credits stay at CREDITS.
REQ-033 SHALL test done_i in the same cycle as issue -> credits unchanged; reset asserted after 5 words -> no o_valid, s_ready=1 after release.
REQ-034 SHALL test random s_valid gaps -> block contents identical to the gap-free case.
